// File: rtl/bcd_to_bin_seq_if.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq_if
//   Bundles the BCD-to-binary converter's handshake and data signals.
//
//   Parameters
//     NDIGITS    number of packed BCD digits on bcd_in
//     OUT_W      binary result width
//
//   Signals
//     in_valid   producer -> converter   bcd_in is valid
//     in_ready   converter -> producer   converter can accept a new value
//     bcd_in     producer -> converter   packed BCD, digit 0 in [3:0]
//     out_valid  converter -> consumer   result valid, held until out_ready
//     out_ready  consumer -> converter   consumer takes the result
//     bin_out    converter -> consumer   binary result
//     ovf        converter -> consumer   value did not fit, bin_out saturated
//     err        converter -> consumer   an input digit was > 9, bin_out = 0
//     busy       converter -> any        conversion in flight or result pending
//
//   Modports
//     master     producer/consumer side (testbench or upstream logic)
//     slave      converter side
// ---------------------------------------------------------------------------
interface bcd_to_bin_seq_if #(
    parameter int NDIGITS = 4,
    parameter int OUT_W   = 11
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4*NDIGITS-1:0]   bcd_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       bin_out;
    logic                   ovf;
    logic                   err;
    logic                   busy;

    modport master (
        output in_valid, bcd_in, out_ready,
        input  in_ready, out_valid, bin_out, ovf, err, busy
    );

    modport slave (
        input  in_valid, bcd_in, out_ready,
        output in_ready, out_valid, bin_out, ovf, err, busy
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
//   Sequential packed-BCD to binary converter (reverse double-dabble, one
//   shift per clock). Inverse of the binary-to-BCD display path; used on
//   keypad/entry values that arrive as BCD.
//
//   Ports
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     bus     bcd_to_bin_seq_if.slave: in_valid/in_ready/bcd_in on the input
//             side, out_valid/out_ready/bin_out/ovf/err on the output side,
//             plus busy.
//
//   Flow: IDLE -> CONVERT (CONV_W shifts) -> DONE -> IDLE. An input with a
//   digit > 9 skips CONVERT and reports err straight away.
// ---------------------------------------------------------------------------
module bcd_to_bin_seq #(
    parameter int NDIGITS = 4,
    parameter int OUT_W   = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_to_bin_seq_if.slave   bus
);

    // Bits needed to hold the largest NDIGITS-digit decimal value.
    function automatic int conv_width(input int nd);
        longint unsigned v;
        int              w;
        v = 1;
        for (int i = 0; i < nd; i++) begin
            v = v * 10;
        end
        w = 0;
        for (int b = 0; b < 63; b++) begin
            if ((64'd1 << b) < v) begin
                w = b + 1;
            end
        end
        return w;
    endfunction

    localparam int BCD_W  = 4 * NDIGITS;
    localparam int CONV_W = conv_width(NDIGITS);
    localparam int CNT_W  = $clog2(CONV_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CONV_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic [BCD_W-1:0]    bcd_q,     bcd_d;
    logic [CONV_W-1:0]   bin_q,     bin_d;
    logic [CNT_W-1:0]    count_q,   count_d;
    logic [OUT_W-1:0]    bin_out_q, bin_out_d;
    logic                ovf_q,     ovf_d;
    logic                err_q,     err_d;
    // Holds in_ready low until the first edge after reset is released.
    logic                armed_q;

    // ------------------------------------------------------------------
    // Input digit validity
    // ------------------------------------------------------------------
    logic [NDIGITS-1:0]  digit_bad;
    logic                any_bad;

    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit_chk
            assign digit_bad[gi] = (bus.bcd_in[4*gi +: 4] > 4'd9);
        end
    endgenerate

    assign any_bad = |digit_bad;

    // ------------------------------------------------------------------
    // One reverse double-dabble iteration: shift right, then pull every
    // nibble that landed at >= 8 back by 3 (undoes the x2 of a BCD digit
    // that received a carry-in from the digit above).
    // ------------------------------------------------------------------
    logic [BCD_W+CONV_W-1:0] shift_w;
    logic [BCD_W-1:0]        bcd_adj;
    logic [CONV_W-1:0]       bin_step;

    assign shift_w  = {bcd_q, bin_q} >> 1;
    assign bin_step = shift_w[CONV_W-1:0];

    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_nib_adj
            logic [3:0] nib;
            assign nib                = shift_w[CONV_W + 4*gi +: 4];
            assign bcd_adj[4*gi +: 4] = nib[3] ? (nib - 4'd3) : nib;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Result mapping onto OUT_W with saturation
    // ------------------------------------------------------------------
    logic                ovf_calc;
    logic [OUT_W-1:0]    sat_val;

    generate
        if (CONV_W > OUT_W) begin : g_sat
            assign ovf_calc = |bin_step[CONV_W-1:OUT_W];
            assign sat_val  = ovf_calc ? {OUT_W{1'b1}} : bin_step[OUT_W-1:0];
        end else begin : g_zext
            assign ovf_calc = 1'b0;
            assign sat_val  = OUT_W'(bin_step);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        count_d   = count_q;
        bin_out_d = bin_out_q;
        ovf_d     = ovf_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && bus.in_valid) begin
                    bcd_d   = bus.bcd_in;
                    bin_d   = '0;
                    count_d = '0;
                    if (any_bad) begin
                        bin_out_d = '0;
                        ovf_d     = 1'b0;
                        err_d     = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d   = ST_CONVERT;
                    end
                end
            end

            ST_CONVERT: begin
                bcd_d   = bcd_adj;
                bin_d   = bin_step;
                count_d = count_q + 1'b1;
                // Final shift: load outputs from this iteration's result so
                // out_valid rises CONV_W edges after the accept.
                if (count_q == LAST_CNT) begin
                    bin_out_d = sat_val;
                    ovf_d     = ovf_calc;
                    err_d     = 1'b0;
                    state_d   = ST_DONE;
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            count_q   <= '0;
            bin_out_q <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            count_q   <= count_d;
            bin_out_q <= bin_out_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            armed_q   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = (state_q == ST_IDLE) && armed_q;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q == ST_CONVERT) || (state_q == ST_DONE);
    assign bus.bin_out   = bin_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin_seq
//   Directed bench for bcd_to_bin_seq at NDIGITS=4, OUT_W=11 (CONV_W=14).
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

    localparam int LATENCY = 14;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bcd_to_bin_seq_if #(.NDIGITS(4), .OUT_W(11)) bus ();

    bcd_to_bin_seq #(
        .NDIGITS (4),
        .OUT_W   (11)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for in_ready, present bcd for one edge, return on the
    // falling edge right after the accepting edge.
    task automatic send(input logic [15:0] bcd);
        int waited;
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("in_ready_before_accept", bus.in_ready, 1);
        bus.bcd_in   = bcd;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Count edges after the accepting edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic convert(input logic [15:0] bcd, input logic [10:0] exp_bin,
                           input logic exp_ovf, input logic exp_err);
        int lat;
        send(bcd);
        if (exp_err) begin
            // Invalid digit: result visible in the cycle right after accept.
            chk("err_out_valid_next_cycle", bus.out_valid, 1);
            lat = 0;
        end else begin
            chk("busy_after_accept", bus.busy, 1);
            wait_result(lat);
            chk("latency", lat, LATENCY);
        end
        chk("bin_out", bus.bin_out, exp_bin);
        chk("ovf", bus.ovf, exp_ovf);
        chk("err", bus.err, exp_err);
        $display("bcd=%04h -> bin=%03h ovf=%0b err=%0b lat=%0d (exp bin=%03h ovf=%0b err=%0b)",
                 bcd, bus.bin_out, bus.ovf, bus.err, lat, exp_bin, exp_ovf, exp_err);
    endtask

    initial begin
        int lat;

        bus.in_valid  = 1'b0;
        bus.bcd_in    = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        #1;
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_bin_out", bus.bin_out, 0);
        chk("reset_busy", bus.busy, 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", bus.in_ready, 1);

        //       bcd        bin      ovf   err
        convert(16'h0000, 11'h000, 1'b0, 1'b0);
        convert(16'h1999, 11'h7CF, 1'b0, 1'b0);   // 1999
        convert(16'h2047, 11'h7FF, 1'b0, 1'b0);   // 2047, largest fit
        convert(16'h2048, 11'h7FF, 1'b1, 1'b0);   // first overflow
        convert(16'h9999, 11'h7FF, 1'b1, 1'b0);
        convert(16'h12A4, 11'h000, 1'b0, 1'b1);   // digit A invalid
        convert(16'h1234, 11'h4D2, 1'b0, 1'b0);   // 1234
        convert(16'h0100, 11'h064, 1'b0, 1'b0);   // 100

        // Back-pressure: hold the result for 5 cycles with in_valid asserted.
        send(16'h0042);
        bus.out_ready = 1'b0;
        wait_result(lat);
        chk("hold_latency", lat, LATENCY);
        bus.in_valid = 1'b1;
        bus.bcd_in   = 16'h0777;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_bin_out", bus.bin_out, 11'd42);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        $display("bcd=0042 held 5 cycles, bin=%03h", bus.bin_out);
        bus.out_ready = 1'b1;
        @(negedge clk);
        // Handshake edge: no accept of the still-valid input on this edge.
        chk("handshake_out_valid", bus.out_valid, 0);
        chk("handshake_busy", bus.busy, 0);
        chk("handshake_in_ready", bus.in_ready, 1);
        chk("bin_out_kept", bus.bin_out, 11'd42);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);

        // Asynchronous reset in the middle of a conversion.
        send(16'h1234);
        repeat (6) @(negedge clk);
        chk("midconv_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_bin_out", bus.bin_out, 0);
        chk("async_rst_ovf", bus.ovf, 0);
        chk("async_rst_err", bus.err, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_in_ready", bus.in_ready, 0);
        $display("reset pulsed mid-conversion of bcd=1234");
        @(negedge clk);
        rst_n = 1'b1;
        convert(16'h0005, 11'h005, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
